toggle_pulse_gen: RTL and testbench
===================================

# toggle_pulse_gen

Programmable-period strobe generator that drives the `t` input of the team's toggle flip-flop. It produces a single-cycle toggle pulse every P clocks, so the downstream flip-flop outputs a square wave of period 2·P clocks. It supports start/stop control, a pulse counter and, when configured, finite bursts with a completion strobe.

## Interface
- `CNT_W`, default 16: width of the period register and down-counter.
- `BURST_W`, default 8: width of the burst length and the pulse counter.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  level sampled each edge; begins a run when idle.
- `stop`  in  1  level sampled each edge; aborts a run.
- `period`  in  CNT_W  pulse spacing P in clocks; sampled on accepted start.
- `burst_len`  in  BURST_W  pulses per run N; sampled on accepted start; 0 means continuous.
- `t_out`  out  1  registered toggle strobe; connects to the flip-flop `t` input.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle strobe marking burst completion.
- `pulse_cnt`  out  BURST_W  number of pulses issued in the current or last run.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `t_out`=0, `busy`=0, `done`=0, `pulse_cnt`=0, internal counter=0, latched period=0, latched burst=0.
- IDLE → RUN on an edge with `start`=1 and `stop`=0:
  - latch P = `period`; P=0 is treated as P=1.
  - latch N = `burst_len`.
  - load the down-counter with P−1.
  - clear `pulse_cnt`.
- RUN behaviour:
  - The counter decrements each edge.
  - On an edge where counter==0, the counter reloads P−1, `t_out` is registered high for one cycle and `pulse_cnt` increments. Otherwise `t_out` is registered low.
- Burst end: in RUN, the edge that issues pulse number N (N≠0) also moves the FSM to DONE.
- DONE → IDLE unconditionally after one cycle. `done`=1 only while in DONE.
- `stop`=1 on any edge in RUN:
  - next state is IDLE and `t_out` is registered low, even if a pulse was due on that edge.
  - `done` is not asserted.
  - `pulse_cnt` holds its value.
- `start` during RUN or DONE is ignored; `period` and `burst_len` changes during a run are ignored.
- `start`=1 with `stop`=1 in IDLE: stop wins and the FSM remains IDLE.
- Continuous mode (N=0): `pulse_cnt` wraps modulo 2^BURST_W; the run continues until `stop`.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronously) and the FSM returns to IDLE.

## Timing
- Start accepted at edge E0 → `busy` high from E0.
- First `t_out` high cycle follows edge E0+P; later pulses follow edges E0+2P, E0+3P, …
- P=1 → `t_out` high in every cycle from the cycle after E0+1.
- Burst N (N≠0):
  - last pulse follows edge E0+N·P, where the FSM enters DONE;
  - `busy` falls and `done` is high in that same cycle;
  - IDLE is reached at edge E0+N·P+1.
  - `t_out` and `done` are high in the same cycle.
- Earliest new start: the edge at which the FSM is back in IDLE, i.e. the edge after DONE.
- Downstream flip-flop output period is 2·P clocks with 50% duty.

## Configuration
- Macro: `TOGGLE_PULSE_GEN_BURST_EN`.
- Defined: burst logic, the DONE state and the `done` strobe are present, as described above.
- Undefined:
  - the `burst_len` port exists but is ignored; every run is continuous;
  - the DONE state is not built and `done` is tied to 0;
  - a run ends only via `stop` or reset;
  - `pulse_cnt` still counts and wraps.

## Test plan
- Reset, then start with `period`=4 and `burst_len`=0 → `t_out` pulses after edges E0+4, +8, +12; `pulse_cnt` reads 1, 2, 3; `busy`=1 throughout.
- Start with `period`=3 and `burst_len`=2 (macro defined) → pulses after E0+3 and E0+6; `done`=1 and `busy`=0 in the second pulse cycle; IDLE at E0+7; `pulse_cnt`=2 holds afterwards.
- Start with `period`=0 → treated as P=1: `t_out` high every cycle; downstream flip-flop toggles every cycle.
- `period`=5, assert `stop` at E0+5 → no pulse on that edge, FSM returns to IDLE, `done` stays 0, `pulse_cnt`=0.
- Assert `start` and `stop` together in IDLE → FSM stays IDLE. Pulse `start` mid-run with a different `period` → spacing unchanged.
- Assert `rst_n`=0 mid-run at `pulse_cnt`=7 → all outputs 0 immediately; after release, a new start with `period`=2 pulses after E0+2.

Source files
------------

// File: rtl/toggle_pulse_gen.sv
// Programmable-period strobe generator feeding a toggle flip-flop's t input.
// Define TOGGLE_PULSE_GEN_BURST_EN to build finite bursts, the DONE state and the done strobe.
module toggle_pulse_gen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   period,
    input  logic [BURST_W-1:0] burst_len,
    output logic               t_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);

`ifdef TOGGLE_PULSE_GEN_BURST_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   per_q, per_d;
    logic [BURST_W-1:0] pcnt_q, pcnt_d;
    logic               t_q, t_d;
    logic [CNT_W-1:0]   per_eff;
    logic [BURST_W-1:0] pcnt_inc;

`ifdef TOGGLE_PULSE_GEN_BURST_EN
    logic [BURST_W-1:0] burst_q, burst_d;
`else
    // Burst length is accepted on the port but every run is continuous here.
    logic unused_burst;
    assign unused_burst = ^burst_len;
`endif

    // A zero period would never reload cleanly; run it as P=1.
    assign per_eff  = (period == '0) ? CNT_W'(1) : period;
    assign pcnt_inc = pcnt_q + BURST_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        pcnt_d  = pcnt_q;
        t_d     = 1'b0;
`ifdef TOGGLE_PULSE_GEN_BURST_EN
        burst_d = burst_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    per_d   = per_eff;
                    cnt_d   = per_eff - CNT_W'(1);
                    pcnt_d  = '0;
`ifdef TOGGLE_PULSE_GEN_BURST_EN
                    burst_d = burst_len;
`endif
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    cnt_d  = per_q - CNT_W'(1);
                    t_d    = 1'b1;
                    pcnt_d = pcnt_inc;
`ifdef TOGGLE_PULSE_GEN_BURST_EN
                    // The edge issuing pulse N also ends the burst.
                    if ((burst_q != '0) && (pcnt_inc == burst_q)) begin
                        state_d = DONE;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef TOGGLE_PULSE_GEN_BURST_EN
            DONE: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= '0;
            pcnt_q  <= '0;
            t_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            pcnt_q  <= pcnt_d;
            t_q     <= t_d;
        end
    end

`ifdef TOGGLE_PULSE_GEN_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

    assign done = (state_q == DONE);
`else
    assign done = 1'b0;
`endif

    assign busy      = (state_q == RUN);
    assign t_out     = t_q;
    assign pulse_cnt = pcnt_q;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Self-checking bench for toggle_pulse_gen: vector table, directed corner cases, random run vs. model.
module tb_toggle_pulse_gen;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;
`ifdef TOGGLE_PULSE_GEN_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [CNT_W-1:0]   period = '0;
    logic [BURST_W-1:0] burst_len = '0;
    logic               t_out, busy, done;
    logic [BURST_W-1:0] pulse_cnt;

    toggle_pulse_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .period(period), .burst_len(burst_len),
        .t_out(t_out), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a run is "k edges since the accepted start"; a pulse
    // falls on every k that is a multiple of P, and a burst ends at k = N*P.
    bit m_run, m_done, m_t;
    int m_k, m_P, m_N, m_pulses;

    task automatic model_reset();
        m_run = 0; m_done = 0; m_t = 0; m_k = 0; m_P = 0; m_N = 0; m_pulses = 0;
    endtask

    task automatic model_edge();
        if (m_done) begin
            m_done = 0;
            m_t    = 0;
        end else if (m_run) begin
            if (stop) begin
                m_run = 0;
                m_t   = 0;
            end else begin
                m_k++;
                m_t = ((m_k % m_P) == 0);
                if (m_t) m_pulses++;
                if (BURST_EN && m_N != 0 && m_k == m_N * m_P) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end else begin
            m_t = 0;
            if (start && !stop) begin
                m_run    = 1;
                m_k      = 0;
                m_P      = (period == 0) ? 1 : int'(period);
                m_N      = int'(burst_len);
                m_pulses = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".t_out"}, 32'(t_out), 32'(m_t));
        chk({tag, ".busy"}, 32'(busy), 32'(m_run));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".pulse_cnt"}, 32'(pulse_cnt), 32'(m_pulses % 256));
    endtask

    // One clock edge: model advances on the inputs present at the edge, outputs sampled 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk_model(tag);
    endtask

    typedef struct {
        logic               start;
        logic               stop;
        logic [CNT_W-1:0]   period;
        logic [BURST_W-1:0] burst;
        logic               t;
        logic               busy;
        logic [BURST_W-1:0] cnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Period 4, continuous; a start with period 7 at row 6 must be ignored; stop at row 13.
        for (int i = 0; i < 14; i++) begin
            tbl[i].start  = (i == 0 || i == 6);
            tbl[i].stop   = (i == 13);
            tbl[i].period = (i == 6) ? 16'd7 : 16'd4;
            tbl[i].burst  = 8'd0;
            tbl[i].t      = (i == 4 || i == 8 || i == 12);
            tbl[i].busy   = (i != 13);
            tbl[i].cnt    = (i < 4) ? 8'd0 : (i < 8) ? 8'd1 : (i < 12) ? 8'd2 : 8'd3;
        end

        model_reset();
        #12;
        chk("reset.t_out", 32'(t_out), 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.done", 32'(done), 0);
        chk("reset.pulse_cnt", 32'(pulse_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step("idle");

        for (int i = 0; i < 14; i++) begin
            start = tbl[i].start; stop = tbl[i].stop;
            period = tbl[i].period; burst_len = tbl[i].burst;
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.t_out", i), 32'(t_out), 32'(tbl[i].t));
            chk($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d.done", i), 32'(done), 0);
            chk($sformatf("tbl%0d.pulse_cnt", i), 32'(pulse_cnt), 32'(tbl[i].cnt));
        end
        start = 0; stop = 0;
        step("post_tbl");

        // Burst of 2 at period 3.
        start = 1; period = 3; burst_len = 2;
        step("burst.e0");
        start = 0; period = 9; burst_len = 5;
        for (int k = 1; k <= 5; k++) step($sformatf("burst.e%0d", k));
        step("burst.e6");
        chk("burst.e6.t_out", 32'(t_out), 1);
        chk("burst.e6.pulse_cnt", 32'(pulse_cnt), 2);
        chk("burst.e6.done", 32'(done), BURST_EN ? 1 : 0);
        chk("burst.e6.busy", 32'(busy), BURST_EN ? 0 : 1);
        step("burst.e7");
        chk("burst.e7.t_out", 32'(t_out), 0);
        chk("burst.e7.done", 32'(done), 0);
        chk("burst.e7.busy", 32'(busy), BURST_EN ? 0 : 1);
        chk("burst.e7.pulse_cnt", 32'(pulse_cnt), 2);
        stop = 1;
        step("burst.stop");
        stop = 0;
        step("burst.hold");
        chk("burst.hold.pulse_cnt", 32'(pulse_cnt), 2);

        // Stop exactly on a due pulse edge.
        start = 1; period = 5; burst_len = 0;
        step("stop.e0");
        start = 0;
        for (int k = 1; k <= 4; k++) step($sformatf("stop.e%0d", k));
        stop = 1;
        step("stop.e5");
        chk("stop.e5.t_out", 32'(t_out), 0);
        chk("stop.e5.busy", 32'(busy), 0);
        chk("stop.e5.done", 32'(done), 0);
        chk("stop.e5.pulse_cnt", 32'(pulse_cnt), 0);

        // Start and stop together in IDLE.
        start = 1; stop = 1;
        step("startstop");
        chk("startstop.busy", 32'(busy), 0);
        start = 0; stop = 0;
        step("startstop.idle");

        // Period 0 runs as P=1, then asynchronous reset at pulse_cnt = 7.
        start = 1; period = 0;
        step("p0.e0");
        start = 0;
        for (int k = 1; k <= 7; k++) begin
            step($sformatf("p0.e%0d", k));
            chk($sformatf("p0.e%0d.t_out", k), 32'(t_out), 1);
        end
        chk("p0.pulse_cnt", 32'(pulse_cnt), 7);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.t_out", 32'(t_out), 0);
        chk("arst.busy", 32'(busy), 0);
        chk("arst.pulse_cnt", 32'(pulse_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1; period = 2;
        step("rst2.e0");
        start = 0;
        step("rst2.e1");
        chk("rst2.e1.t_out", 32'(t_out), 0);
        step("rst2.e2");
        chk("rst2.e2.t_out", 32'(t_out), 1);
        chk("rst2.e2.pulse_cnt", 32'(pulse_cnt), 1);
        stop = 1;
        step("rst2.stop");
        stop = 0;

        // Random start/stop/period/burst traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom % 4) == 0;
            stop      = ($urandom % 16) == 0;
            period    = CNT_W'($urandom % 6);
            burst_len = BURST_W'($urandom % 4);
            step($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
